branch_predictor: RTL and testbench

// - Fetch-side dynamic branch predictor: the producer of the predicted next PC that
//   the EX-stage next-PC unit later confirms or overturns.
// - Direct-mapped BTB with a 2-bit saturating counter per entry. Looked up with pc_if
//   in IF; trained with the resolved outcome from EX.
// - Raises mispredict/redirect_pc so the pipeline flushes IF/ID and refetches.
// - PCs are word addresses; sequential successor is pc+1.

---
 rtl/bp_pkg.sv | 20 ++
 rtl/bp_sat_ctr.sv | 20 ++
 rtl/branch_predictor.sv | 117 +++++++++++
 tb/tb_branch_predictor.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and constants for the fetch-side branch predictor.
package bp_pkg;

   // 2-bit saturating counter states; bit 1 set means "predict taken".
   localparam logic [1:0] CTR_SNT   = 2'b00;
   localparam logic [1:0] CTR_WNT   = 2'b01;
   localparam logic [1:0] CTR_WT    = 2'b10;
   localparam logic [1:0] CTR_ST    = 2'b11;
   localparam logic [1:0] CTR_ALLOC = CTR_WT;

   // One BTB entry. The tag field holds pc >> IDX_W zero-extended to 32 bits so
   // the same struct serves any table size; the upper IDX_W bits stay zero.
   typedef struct packed {
      logic        valid;
      logic [31:0] tag;
      logic [31:0] target;
      logic [1:0]  ctr;
   } btb_entry_t;

endpackage

// File: rtl/bp_sat_ctr.sv
// Next-state logic for a 2-bit saturating taken/not-taken counter.
module bp_sat_ctr
   import bp_pkg::*;
(
   input  logic [1:0] ctr_in,
   input  logic       taken,
   output logic [1:0] ctr_out
);

   // Step toward ST on taken and toward SNT on not-taken, holding at both ends.
   always_comb begin
      ctr_out = ctr_in;
      if (taken) begin
         if (ctr_in != CTR_ST) ctr_out = ctr_in + 2'd1;
      end else begin
         if (ctr_in != CTR_SNT) ctr_out = ctr_in - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: predicts in IF, trains from EX.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        halt,
   input  logic [31:0] pc_if,
   output logic        pred_taken,
   output logic [31:0] pred_pc,
   input  logic        ex_branch,
   input  logic [31:0] pc_ex,
   input  logic        ex_taken,
   input  logic [31:0] ex_next_pc,
   input  logic [31:0] pred_pc_ex,
   output logic        mispredict,
   output logic [31:0] redirect_pc,
   output logic [31:0] branch_cnt,
   output logic [31:0] mispredict_cnt
);

   btb_entry_t btb_q [ENTRIES];
   btb_entry_t btb_d [ENTRIES];
   logic       wr_en [ENTRIES];

   logic [31:0] branch_cnt_q, branch_cnt_d;
   logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

   logic [IDX_W-1:0] if_idx, ex_idx;
   logic [31:0]      if_tag, ex_tag;
   btb_entry_t       if_entry, ex_entry;
   logic             if_hit, ex_hit, train;
   logic [1:0]       ctr_next;

   assign if_idx   = pc_if[IDX_W-1:0];
   assign ex_idx   = pc_ex[IDX_W-1:0];
   assign if_tag   = pc_if >> IDX_W;
   assign ex_tag   = pc_ex >> IDX_W;
   assign if_entry = btb_q[if_idx];
   assign ex_entry = btb_q[ex_idx];
   assign if_hit   = if_entry.valid && (if_entry.tag == if_tag);
   assign ex_hit   = ex_entry.valid && (ex_entry.tag == ex_tag);
   assign train    = ex_branch && !halt && !rst;

   // Single write port: the counter update for whichever entry EX is training.
   bp_sat_ctr u_sat_ctr (
      .ctr_in  (ex_entry.ctr),
      .taken   (ex_taken),
      .ctr_out (ctr_next)
   );

   // IF-side lookup and EX-side mispredict detection, both purely combinational.
   always_comb begin
      pred_taken  = if_hit && if_entry.ctr[1];
      pred_pc     = pred_taken ? if_entry.target : pc_if + 32'd1;
      mispredict  = ex_branch && !halt && !rst && (ex_next_pc != pred_pc_ex);
      redirect_pc = ex_next_pc;
   end

   // Decode the trained index into one write enable per entry.
   always_comb begin
      for (int i = 0; i < ENTRIES; i++) begin
         wr_en[i] = train && (ex_idx == IDX_W'(i));
      end
   end

   // Next table contents: update on a hit, allocate on a taken miss, else hold.
   always_comb begin
      for (int i = 0; i < ENTRIES; i++) begin
         btb_d[i] = btb_q[i];
         if (wr_en[i]) begin
            if (ex_hit) begin
               btb_d[i].ctr = ctr_next;
               if (ex_taken) btb_d[i].target = ex_next_pc;
            end else if (ex_taken) begin
               btb_d[i].valid  = 1'b1;
               btb_d[i].tag    = ex_tag;
               btb_d[i].target = ex_next_pc;
               btb_d[i].ctr    = CTR_ALLOC;
            end
         end
      end
   end

   // Statistics counters, wrapping naturally at 2^32.
   always_comb begin
      branch_cnt_d     = branch_cnt_q + (train ? 32'd1 : 32'd0);
      mispredict_cnt_d = mispredict_cnt_q + (mispredict ? 32'd1 : 32'd0);
   end

   // State registers; reset wins over any training in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            btb_q[i].valid  <= 1'b0;
            btb_q[i].tag    <= '0;
            btb_q[i].target <= '0;
            btb_q[i].ctr    <= CTR_WNT;
         end
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            btb_q[i] <= btb_d[i];
         end
         branch_cnt_q     <= branch_cnt_d;
         mispredict_cnt_q <= mispredict_cnt_d;
      end
   end

   assign branch_cnt     = branch_cnt_q;
   assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor against a behavioural BTB model.
module tb_branch_predictor;

   logic        clk;
   logic        rst;
   logic        halt;
   logic [31:0] pc_if;
   logic        pred_taken;
   logic [31:0] pred_pc;
   logic        ex_branch;
   logic [31:0] pc_ex;
   logic        ex_taken;
   logic [31:0] ex_next_pc;
   logic [31:0] pred_pc_ex;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic [31:0] branch_cnt;
   logic [31:0] mispredict_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        pred_taken;
      logic [31:0] pred_pc;
      logic        mispredict;
      logic [31:0] redirect_pc;
      logic [31:0] branch_cnt;
      logic [31:0] mispredict_cnt;
   } expect_t;

   expect_t sb_q[$];

   // Reference model: a plain 16-slot table indexed by pc mod 16.
   bit          m_valid  [16];
   int unsigned m_tag    [16];
   int unsigned m_target [16];
   int          m_ctr    [16];
   int unsigned m_bcnt;
   int unsigned m_mcnt;

   branch_predictor #(.ENTRIES(16), .IDX_W(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .halt           (halt),
      .pc_if          (pc_if),
      .pred_taken     (pred_taken),
      .pred_pc        (pred_pc),
      .ex_branch      (ex_branch),
      .pc_ex          (pc_ex),
      .ex_taken       (ex_taken),
      .ex_next_pc     (ex_next_pc),
      .pred_pc_ex     (pred_pc_ex),
      .mispredict     (mispredict),
      .redirect_pc    (redirect_pc),
      .branch_cnt     (branch_cnt),
      .mispredict_cnt (mispredict_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void modelReset();
      for (int i = 0; i < 16; i++) begin
         m_valid[i]  = 1'b0;
         m_tag[i]    = 0;
         m_target[i] = 0;
         m_ctr[i]    = 1;
      end
      m_bcnt = 0;
      m_mcnt = 0;
   endfunction

   function automatic bit modelHit(int unsigned pc);
      return m_valid[pc % 16] && (m_tag[pc % 16] == pc / 16);
   endfunction

   function automatic int unsigned modelPredict(int unsigned pc, output bit taken);
      taken = modelHit(pc) && (m_ctr[pc % 16] >= 2);
      return taken ? m_target[pc % 16] : pc + 1;
   endfunction

   task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput(expect_t e);
      cmp("pred_taken", 32'(pred_taken), 32'(e.pred_taken));
      cmp("pred_pc", pred_pc, e.pred_pc);
      cmp("mispredict", 32'(mispredict), 32'(e.mispredict));
      if (e.mispredict) cmp("redirect_pc", redirect_pc, e.redirect_pc);
      cmp("branch_cnt", branch_cnt, e.branch_cnt);
      cmp("mispredict_cnt", mispredict_cnt, e.mispredict_cnt);
   endtask

   // Drive one cycle of inputs, push the expected response, then advance the model.
   task automatic applyStimulus(bit r, bit h, int unsigned pif, bit br,
                                int unsigned pex, bit tk, int unsigned nxt, int unsigned ppex);
      expect_t     e;
      bit          t;
      bit          tr;
      int          idx;
      @(posedge clk);
      #1;
      rst = r; halt = h; pc_if = pif; ex_branch = br;
      pc_ex = pex; ex_taken = tk; ex_next_pc = nxt; pred_pc_ex = ppex;
      e.pred_pc        = modelPredict(pif, t);
      e.pred_taken     = t;
      e.mispredict     = br && !h && !r && (nxt != ppex);
      e.redirect_pc    = nxt;
      e.branch_cnt     = m_bcnt;
      e.mispredict_cnt = m_mcnt;
      sb_q.push_back(e);
      tr = br && !h && !r;
      if (r) begin
         modelReset();
      end else if (tr) begin
         idx = int'(pex % 16);
         m_bcnt++;
         if (e.mispredict) m_mcnt++;
         if (modelHit(pex)) begin
            if (tk) begin
               m_ctr[idx]    = (m_ctr[idx] + 1 > 3) ? 3 : m_ctr[idx] + 1;
               m_target[idx] = nxt;
            end else begin
               m_ctr[idx] = (m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1;
            end
         end else if (tk) begin
            m_valid[idx]  = 1'b1;
            m_tag[idx]    = pex / 16;
            m_target[idx] = nxt;
            m_ctr[idx]    = 2;
         end
      end
   endtask

   // Monitor: combinational outputs are presented every cycle, so pop one per negedge.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         checkOutput(sb_q.pop_front());
      end
   end

   initial begin
      int unsigned pool [8];
      int unsigned pex, nxt, ppex, pif;
      bit          tk, dummy;
      pool = '{32'h20, 32'h30, 32'h21, 32'h05, 32'h15, 32'h3F, 32'h0F, 32'hFFFF_FFFF};

      rst = 1'b1; halt = 1'b0; pc_if = 0; ex_branch = 1'b0;
      pc_ex = 0; ex_taken = 1'b0; ex_next_pc = 0; pred_pc_ex = 0;
      repeat (2) @(posedge clk);
      modelReset();

      // Directed sequence: cold lookup, cold taken branch, counter walk.
      applyStimulus(0, 0, 32'h10, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 32'h10, 1, 32'h20, 1, 32'h28, 32'h21);
      applyStimulus(0, 0, 32'h20, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 32'h20, 1, 32'h20, 0, 32'h21, 32'h28);
      applyStimulus(0, 0, 32'h20, 1, 32'h20, 0, 32'h21, 32'h21);
      applyStimulus(0, 0, 32'h20, 0, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(0, 0, 32'h20, 1, 32'h20, 1, 32'h28, 32'h21);
         applyStimulus(0, 0, 32'h20, 0, 0, 0, 0, 0);
      end
      applyStimulus(0, 0, 32'h20, 1, 32'h20, 0, 32'h21, 32'h28);
      applyStimulus(0, 0, 32'h20, 0, 0, 0, 0, 0);

      // Alias into entry 0.
      applyStimulus(0, 0, 32'h30, 1, 32'h30, 1, 32'h40, 32'h31);
      applyStimulus(0, 0, 32'h20, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 32'h30, 0, 0, 0, 0, 0);

      // Halted resolution must not train or count.
      applyStimulus(0, 1, 32'h30, 1, 32'h30, 0, 32'h31, 32'h99);
      applyStimulus(0, 0, 32'h30, 0, 0, 0, 0, 0);

      // Mid-run reset with a branch pending, then a same-cycle train/lookup.
      applyStimulus(1, 0, 32'h30, 1, 32'h30, 0, 32'h31, 32'h99);
      applyStimulus(0, 0, 32'h30, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 32'h20, 1, 32'h20, 1, 32'h28, 32'h21);
      applyStimulus(0, 0, 32'h20, 0, 0, 0, 0, 0);

      // Sequential successor wraps at the top of the address space.
      applyStimulus(0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);

      // Randomized traffic over a small PC pool so entries alias and saturate.
      for (int k = 0; k < 600; k++) begin
         pex = pool[$urandom_range(7)];
         pif = pool[$urandom_range(7)];
         tk  = $urandom_range(1);
         nxt = tk ? (32'h100 + $urandom_range(3)) : pex + 1;
         ppex = ($urandom_range(3) != 0) ? modelPredict(pex, dummy) : $urandom;
         applyStimulus(($urandom_range(49) == 0), ($urandom_range(9) == 0), pif,
                       ($urandom_range(3) != 0), pex, tk, nxt, ppex);
      end

      @(posedge clk);
      for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(negedge clk);
      if (sb_q.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain actual=%0d expected=0 pending entries", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
